// File: rtl/note_lane_renderer_if.sv
// note_lane_renderer_if: cell-draw request bus between the lane renderer
// and the VGA plotter. The renderer is the master: it drives the cell
// coordinates and colour. The plotter is the slave: it returns draw_ready.
interface note_lane_renderer_if;
   logic       draw_valid;
   logic       draw_ready;
   logic [7:0] draw_x;
   logic [6:0] draw_y;
   logic [2:0] draw_colour;

   modport master (
      output draw_valid,
      output draw_x,
      output draw_y,
      output draw_colour,
      input  draw_ready
   );

   modport slave (
      input  draw_valid,
      input  draw_x,
      input  draw_y,
      input  draw_colour,
      output draw_ready
   );
endinterface

// File: rtl/note_lane_renderer.sv
// note_lane_renderer: keeps a scrolling history of the last DEPTH beat rows
// for 4 note lanes. Every accepted beat overwrites the oldest row, and the
// evicted row is reported on hit_row. The whole field is then redrawn as
// 4*DEPTH cell-draw requests, row 0 (newest, top) first and lane 0 first
// within each row. A single pending slot absorbs one beat that arrives
// while a push or redraw is in progress. Any further beat is dropped and
// raises the sticky overflow flag.
// Optional build macro LANE_COLOUR_EN: when it is defined, each lane draws
// its notes in its own colour. When it is undefined, every note is drawn
// in white.
module note_lane_renderer #(
   parameter int DEPTH  = 16,
   parameter int ROW_H  = 7,
   parameter int LANE_W = 16,
   parameter int X0     = 48
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  beat_valid,
   input  logic [7:0]            beat_data,
   note_lane_renderer_if.master  draw,
   output logic                  frame_done,
   output logic                  hit_valid,
   output logic [3:0]            hit_row,
   output logic                  overflow
);

   localparam int PTR_W  = $clog2(DEPTH);
   localparam int CELL_W = PTR_W + 2;
   localparam logic [CELL_W-1:0] LAST_CELL = CELL_W'(4 * DEPTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PUSH = 2'd1,
      DRAW = 2'd2,
      DONE = 2'd3
   } stateE;

   stateE             state_q, state_d;
   logic [3:0]        rows_q [DEPTH];
   logic [PTR_W-1:0]  wrPtr_q;
   logic [CELL_W-1:0] cellIdx_q, cellIdx_d;
   logic              pending_q, pending_d;
   logic [3:0]        pendData_q, pendData_d;
   logic              overflow_q, overflow_d;
   logic              hitValid_q;
   logic [3:0]        hitRow_q;

   logic              pushEn;
   logic [3:0]        pushData;
   logic              handshake;
   logic              lastCell;
   logic [1:0]        cellLane;
   logic [PTR_W-1:0]  cellRow;
   logic [PTR_W-1:0]  physRow;
   logic [3:0]        rowBits;
   logic [2:0]        noteColour;
   logic [3:0]        unusedBeatBits;

   assign unusedBeatBits = beat_data[7:4];

   assign handshake = (state_q == DRAW) && draw.draw_ready;
   assign lastCell  = (cellIdx_q == LAST_CELL);
   assign cellLane  = cellIdx_q[1:0];
   assign cellRow   = cellIdx_q[CELL_W-1:2];
   // The newest row sits just behind the write pointer, so logical row r
   // is r slots further back (wrapping) from that position.
   assign physRow   = wrPtr_q - PTR_W'(1) - cellRow;
   assign rowBits   = rows_q[physRow];

   // Decide whether a row is written this cycle and how a beat that
   // arrives while busy is absorbed (pending slot) or dropped (overflow).
   always_comb begin
      pushEn     = 1'b0;
      pushData   = beat_data[3:0];
      pending_d  = pending_q;
      pendData_d = pendData_q;
      overflow_d = overflow_q;
      unique case (state_q)
         IDLE: pushEn = beat_valid;
         DONE: begin
            pushEn = pending_q || beat_valid;
            if (pending_q) begin
               pushData = pendData_q;
            end
         end
         default: ;
      endcase
      if ((state_q == DONE) && pending_q) begin
         pending_d = 1'b0;
      end
      if (beat_valid && ((state_q == PUSH) || (state_q == DRAW) ||
                         ((state_q == DONE) && pending_q))) begin
         if (pending_q) begin
            overflow_d = 1'b1;
         end else begin
            pending_d  = 1'b1;
            pendData_d = beat_data[3:0];
         end
      end
   end

   // The cell counter restarts for every redraw and advances only when
   // the plotter accepts the current cell.
   always_comb begin
      cellIdx_d = cellIdx_q;
      if (state_q == PUSH) begin
         cellIdx_d = '0;
      end else if (handshake) begin
         cellIdx_d = cellIdx_q + CELL_W'(1);
      end
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state: push, then redraw the field, then a one-cycle done
   // state that chains straight into another push if a beat is waiting.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (beat_valid) state_d = PUSH;
         PUSH: state_d = DRAW;
         DRAW: if (handshake && lastCell) state_d = DONE;
         DONE: state_d = pushEn ? PUSH : IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Select the note colour for the current lane.
   always_comb begin
      noteColour = 3'b111;
`ifdef LANE_COLOUR_EN
      unique case (cellLane)
         2'd0: noteColour = 3'b100;
         2'd1: noteColour = 3'b010;
         2'd2: noteColour = 3'b001;
         default: noteColour = 3'b110;
      endcase
`else
      noteColour = 3'b111;
`endif
   end

   // FSM outputs: drive the cell bus only while drawing. The fields are
   // derived from the cell counter, so they hold while the plotter stalls.
   always_comb begin
      draw.draw_valid  = 1'b0;
      draw.draw_x      = '0;
      draw.draw_y      = '0;
      draw.draw_colour = '0;
      frame_done       = 1'b0;
      if (state_q == DRAW) begin
         draw.draw_valid  = 1'b1;
         draw.draw_x      = 8'(X0 + 32'(cellLane) * LANE_W);
         draw.draw_y      = 7'(32'(cellRow) * ROW_H);
         draw.draw_colour = rowBits[cellLane] ? noteColour : 3'b000;
      end
      if (state_q == DONE) begin
         frame_done = 1'b1;
      end
   end

   // Row storage, write pointer, pending slot, sticky overflow, and the
   // registered eviction report.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            rows_q[i] <= '0;
         end
         wrPtr_q    <= '0;
         cellIdx_q  <= '0;
         pending_q  <= 1'b0;
         pendData_q <= '0;
         overflow_q <= 1'b0;
         hitValid_q <= 1'b0;
         hitRow_q   <= '0;
      end else begin
         if (pushEn) begin
            rows_q[wrPtr_q] <= pushData;
            wrPtr_q         <= wrPtr_q + PTR_W'(1);
         end
         cellIdx_q  <= cellIdx_d;
         pending_q  <= pending_d;
         pendData_q <= pendData_d;
         overflow_q <= overflow_d;
         hitValid_q <= pushEn;
         hitRow_q   <= pushEn ? rows_q[wrPtr_q] : 4'b0000;
      end
   end

   assign hit_valid = hitValid_q;
   assign hit_row   = hitRow_q;
   assign overflow  = overflow_q;

endmodule

// File: tb/tb_note_lane_renderer.sv
// tb_note_lane_renderer: directed and randomized checks of the lane renderer.
// The reference history is a newest-first queue of lane rows, together with
// a single pending slot and an overflow flag. Expected cells are computed
// from that queue for each redraw.
module tb_note_lane_renderer;

   localparam int DEPTH  = 16;
   localparam int NCELLS = 4 * DEPTH;
   localparam int ROW_H  = 7;
   localparam int LANE_W = 16;
   localparam int X0     = 48;

   logic       clk;
   logic       reset;
   logic       beat_valid;
   logic [7:0] beat_data;
   logic       frame_done;
   logic       hit_valid;
   logic [3:0] hit_row;
   logic       overflow;

   note_lane_renderer_if drawIf ();

   note_lane_renderer #(
      .DEPTH  (DEPTH),
      .ROW_H  (ROW_H),
      .LANE_W (LANE_W),
      .X0     (X0)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .beat_valid (beat_valid),
      .beat_data  (beat_data),
      .draw       (drawIf),
      .frame_done (frame_done),
      .hit_valid  (hit_valid),
      .hit_row    (hit_row),
      .overflow   (overflow)
   );

   int checks   = 0;
   int failures = 0;

   logic [3:0] histQ[$];
   logic       pendValid;
   logic [3:0] pendData;
   logic       ovfExp;
   bit         chained;

   // Free-running clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   function automatic logic [2:0] laneColour(input int lane);
`ifdef LANE_COLOUR_EN
      case (lane)
         0: return 3'b100;
         1: return 3'b010;
         2: return 3'b001;
         default: return 3'b110;
      endcase
`else
      return 3'b111;
`endif
   endfunction

   function automatic void modelReset();
      histQ.delete();
      for (int i = 0; i < DEPTH; i++) histQ.push_back(4'h0);
      pendValid = 1'b0;
      pendData  = 4'h0;
      ovfExp    = 1'b0;
   endfunction

   function automatic logic [3:0] modelPush(input logic [3:0] d);
      logic [3:0] ev;
      ev = histQ[DEPTH-1];
      void'(histQ.pop_back());
      histQ.push_front(d);
      return ev;
   endfunction

   function automatic void modelBusyBeat(input logic [3:0] d);
      if (pendValid) begin
         ovfExp = 1'b1;
      end else begin
         pendValid = 1'b1;
         pendData  = d;
      end
   endfunction

   task automatic doReset();
      @(negedge clk);
      reset = 1'b1;
      beat_valid = 1'b0;
      drawIf.draw_ready = 1'b0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      modelReset();
   endtask

   // Beat presented while idle. The eviction must show up on the
   // following cycle.
   task automatic applyStimulus(input logic [7:0] data);
      logic [3:0] ev;
      @(negedge clk);
      beat_valid = 1'b1;
      beat_data  = data;
      ev = modelPush(data[3:0]);
      @(negedge clk);
      beat_valid = 1'b0;
      beat_data  = 8'h00;
      checkOutput("hitValid", hit_valid, 1);
      checkOutput("hitRow", hit_row, ev);
      checkOutput("pushNoDraw", drawIf.draw_valid, 0);
   endtask

   // One redraw: compare every presented cell against the snapshot of the
   // history, optionally injecting busy beats or a reset at given cells.
   task automatic drawOne(input int readyMode, input int b1At, input logic [3:0] b1D,
                          input int b2At, input logic [3:0] b2D, input int resetAt);
      logic [3:0] snap [DEPTH];
      logic [3:0] ev;
      logic [2:0] expCol;
      int n, cyc, row, lane;
      bit inj1, inj2, ready, broke;
      chained = 0;
      for (int i = 0; i < DEPTH; i++) snap[i] = histQ[i];
      n = 0; cyc = 0; inj1 = 0; inj2 = 0; broke = 0;
      while (n < NCELLS && cyc < 4000 && !broke) begin
         @(negedge clk);
         beat_valid = 1'b0;
         if (resetAt >= 0 && n == resetAt) begin
            drawIf.draw_ready = 1'b0;
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
            checkOutput("resetAbortValid", drawIf.draw_valid, 0);
            checkOutput("resetNoFrameDone", frame_done, 0);
            checkOutput("resetHitValid", hit_valid, 0);
            checkOutput("resetOverflow", overflow, 0);
            modelReset();
            return;
         end
         checkOutput("drawValidHeld", drawIf.draw_valid, 1);
         if (drawIf.draw_valid !== 1'b1) begin
            broke = 1;
         end else begin
            row = n / 4;
            lane = n % 4;
            expCol = snap[row][lane] ? laneColour(lane) : 3'b000;
            checkOutput("drawX", drawIf.draw_x, X0 + lane * LANE_W);
            checkOutput("drawY", drawIf.draw_y, row * ROW_H);
            checkOutput("drawColour", drawIf.draw_colour, expCol);
            checkOutput("midFrameDone", frame_done, 0);
            checkOutput("midHitValid", hit_valid, 0);
            case (readyMode)
               0: ready = 1;
               1: ready = (cyc % 3 == 0);
               default: ready = ($urandom_range(1) == 1);
            endcase
            drawIf.draw_ready = ready;
            if (!inj1 && b1At >= 0 && n >= b1At) begin
               beat_valid = 1'b1;
               beat_data = {4'($urandom_range(15)), b1D};
               inj1 = 1;
               modelBusyBeat(b1D);
            end else if (inj1 && !inj2 && b2At >= 0 && n >= b2At) begin
               beat_valid = 1'b1;
               beat_data = {4'($urandom_range(15)), b2D};
               inj2 = 1;
               modelBusyBeat(b2D);
            end
            cyc++;
            if (ready) n++;
         end
      end
      if (n != NCELLS) begin
         checkOutput("frameComplete", n, NCELLS);
         beat_valid = 1'b0;
         drawIf.draw_ready = 1'b0;
         return;
      end
      @(negedge clk);
      beat_valid = 1'b0;
      drawIf.draw_ready = 1'b0;
      checkOutput("frameDone", frame_done, 1);
      checkOutput("doneNoValid", drawIf.draw_valid, 0);
      checkOutput("overflow", overflow, ovfExp);
      if (pendValid) begin
         ev = modelPush(pendData);
         pendValid = 1'b0;
         @(negedge clk);
         checkOutput("pendHitValid", hit_valid, 1);
         checkOutput("pendHitRow", hit_row, ev);
         checkOutput("frameDonePulse", frame_done, 0);
         checkOutput("pendPushNoDraw", drawIf.draw_valid, 0);
         chained = 1;
      end else begin
         @(negedge clk);
         checkOutput("frameDonePulse", frame_done, 0);
         checkOutput("idleAfterDone", drawIf.draw_valid, 0);
      end
   endtask

   task automatic runFrames(input int readyMode, input int b1At, input logic [3:0] b1D,
                            input int b2At, input logic [3:0] b2D, input int resetAt);
      int guard;
      drawOne(readyMode, b1At, b1D, b2At, b2D, resetAt);
      guard = 0;
      while (chained && guard < 8) begin
         drawOne(readyMode, -1, 4'h0, -1, 4'h0, -1);
         guard++;
      end
   endtask

   initial begin
      int b1, b2, nb;
      reset = 1'b1;
      beat_valid = 1'b0;
      beat_data = 8'h00;
      drawIf.draw_ready = 1'b0;
      modelReset();

      // Reset state.
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      checkOutput("rstDrawValid", drawIf.draw_valid, 0);
      checkOutput("rstDrawX", drawIf.draw_x, 0);
      checkOutput("rstDrawY", drawIf.draw_y, 0);
      checkOutput("rstColour", drawIf.draw_colour, 0);
      checkOutput("rstFrameDone", frame_done, 0);
      checkOutput("rstHitValid", hit_valid, 0);
      checkOutput("rstHitRow", hit_row, 0);
      checkOutput("rstOverflow", overflow, 0);
      reset = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         checkOutput("idleNoDraw", drawIf.draw_valid, 0);
      end

      // Single beat with the plotter always ready.
      $display("[TB] single beat");
      applyStimulus(8'hF5);
      runFrames(0, -1, 4'h0, -1, 4'h0, -1);

      // Same field under 1-of-3 backpressure.
      $display("[TB] backpressure");
      doReset();
      applyStimulus(8'hF5);
      runFrames(1, -1, 4'h0, -1, 4'h0, -1);

      // Scroll through more than DEPTH beats so the first one is evicted.
      $display("[TB] scroll and eviction");
      doReset();
      for (int k = 1; k <= 17; k++) begin
         applyStimulus({4'($urandom_range(15)), 4'(k)});
         runFrames(0, -1, 4'h0, -1, 4'h0, -1);
      end

      // One beat mid-redraw goes to the pending slot.
      $display("[TB] pending beat");
      applyStimulus(8'h06);
      runFrames(2, 10, 4'h9, -1, 4'h0, -1);

      // A beat that coincides with the final handshake is not dropped.
      applyStimulus(8'h03);
      runFrames(0, 63, 4'hE, -1, 4'h0, -1);

      // Two beats mid-redraw: the second is dropped and overflow sticks.
      $display("[TB] overflow");
      applyStimulus(8'h0A);
      runFrames(0, 5, 4'hC, 30, 4'h3, -1);
      applyStimulus(8'h0F);
      runFrames(1, -1, 4'h0, -1, 4'h0, -1);

      // Reset in the middle of a redraw.
      $display("[TB] reset mid-redraw");
      applyStimulus(8'h07);
      runFrames(0, -1, 4'h0, -1, 4'h0, 20);
      applyStimulus(8'h0B);
      runFrames(0, -1, 4'h0, -1, 4'h0, -1);

      // Randomized beats, backpressure and busy-beat timing.
      $display("[TB] random frames");
      for (int it = 0; it < 10; it++) begin
         nb = $urandom_range(2);
         b1 = (nb >= 1) ? int'($urandom_range(60)) : -1;
         b2 = (nb >= 2) ? b1 + 1 + int'($urandom_range(2)) : -1;
         applyStimulus(8'($urandom_range(255)));
         runFrames(int'($urandom_range(2)), b1, 4'($urandom_range(15)),
                   b2, 4'($urandom_range(15)), -1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
